eco32f_lsu_writeback: RTL and testbench
=======================================

Name: eco32f_lsu_writeback

Overview:
Memory-stage load/store unit and writeback register for the eco32f pipeline.
- Takes the MEM-stage instruction (ALU result or effective address, store data, load/store control) and runs the single-beat data-bus transaction.
- Aligns and extends big-endian load data.
- Drives the register-file write port (wb_rf_r_addr/we/r), which also serves as the WB bypass source for the register file.
- Stalls the pipeline while a bus access is outstanding.

Parameters:
- DBUS_ADDR_WIDTH, 32, width of dbus_adr; taken from the low bits of mem_alu_result.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- mem_valid  input  1  MEM stage holds a valid instruction
- mem_flush  input  1  kill the MEM-stage instruction (exception/branch flush)
- mem_rf_r_addr  input  5  destination register
- mem_rf_r_we  input  1  instruction writes its destination register
- mem_alu_result  input  32  ALU result; effective address for load/store
- mem_op_load  input  1  instruction is a load
- mem_op_store  input  1  instruction is a store
- mem_lsu_size  input  2  access size: 0=byte, 1=half, 2=word, 3=reserved (treated as word)
- mem_lsu_signed  input  1  sign-extend load data (byte/half only)
- mem_store_data  input  32  store data, right-justified
- mem_stall  output  1  hold MEM and all earlier stages
- dbus_cyc  output  1  bus request, held until ack/err
- dbus_we  output  1  write access
- dbus_adr  output  DBUS_ADDR_WIDTH  word address, bits [1:0] forced to 0
- dbus_sel  output  4  byte lanes; sel[3] is bits 31:24 (big-endian byte 0)
- dbus_dat_o  output  32  write data, lane-replicated
- dbus_dat_i  input  32  read data
- dbus_ack  input  1  transfer complete
- dbus_err  input  1  bus error, terminates the transfer
- wb_rf_r_addr  output  5  register-file write address
- wb_rf_r_we  output  1  register-file write enable
- wb_rf_r  output  32  register-file write data
- wb_except_align  output  1  misaligned access reported at WB
- wb_except_bus  output  1  bus error reported at WB
- wb_except_addr  output  32  faulting effective address

Behaviour:
Definitions:
- access = mem_valid & (mem_op_load | mem_op_store) & !mem_flush.
- misalign = (size half & addr[0]) | (size word/reserved & addr[1:0]!=0).
- start = access & !misalign & state==IDLE.

FSM states: IDLE, BUS.
- IDLE -> BUS on start. Registers capture dbus_adr, dbus_we=mem_op_store, dbus_sel, dbus_dat_o, size/signed/byte offset, and killed=0.
- In BUS, dbus_cyc=1 and all dbus outputs stay stable until dbus_ack|dbus_err.
- BUS -> IDLE on dbus_ack|dbus_err. If both are asserted, err wins.

mem_stall:
- = start | (state==BUS & !(dbus_ack|dbus_err)).
- Deasserts in the ack cycle, so the instruction retires on that edge.
- Minimum load/store latency: 2 cycles in MEM (start cycle + ack cycle).

Lane rules (big-endian):
- byte: sel = 1000 >> addr[1:0]; data replicated to all 4 bytes.
- half: sel = 1100 when addr[1]=0, else 0011; data replicated to both halves.
- word: sel = 1111.

Load alignment:
- Select the lane(s) of dbus_dat_i.
- Zero-extend, or sign-extend when mem_lsu_signed.
- Word loads ignore mem_lsu_signed.

mem_flush while BUS:
- The transaction is never aborted: set killed=1 and continue to ack.
- On completion, wb_rf_r_we=0 and no exception is reported.
- Stores already issued complete on the bus.

WB register update on every edge:
- mem_stall=1: insert a bubble. wb_rf_r_we=0, wb_except_*=0; wb_rf_r_addr and wb_rf_r hold.
- mem_stall=0:
  - wb_rf_r_addr <= mem_rf_r_addr.
  - wb_rf_r <= aligned load data for a load, else mem_alu_result.
  - wb_rf_r_we <= mem_valid & mem_rf_r_we & !mem_flush & !killed & !misalign & !err & !mem_op_store.
  - wb_except_align <= access & misalign. A misaligned access never goes on the bus and has 1-cycle latency.
  - wb_except_bus <= err & !killed.
  - wb_except_addr <= effective address of the faulting access.
- A write to r0 is passed through unchanged; the register file ignores r0 reads.

Reset (rst=1 at an edge, including mid-transaction):
- state=IDLE, killed=0.
- dbus_cyc=0, dbus_we=0, dbus_sel=0, dbus_adr=0, dbus_dat_o=0.
- wb_rf_r_addr=0, wb_rf_r_we=0, wb_rf_r=0, wb_except_*=0.
- mem_stall is low the cycle after reset unless a new start is presented.
- Any outstanding bus transfer is abandoned; the bus fabric is reset alongside.

Test Plan:
- ALU op (r5, result 0x1234_5678, non-memory) -> next cycle wb_rf_r_addr=5, wb_rf_r_we=1, wb_rf_r=0x1234_5678; mem_stall never asserted.
- Signed byte load at 0x1001, dbus_dat_i=0x11_80_22_33, ack 3 cycles after cyc -> dbus_adr=0x1000, sel=0100, mem_stall high 4 cycles, then wb_rf_r=0xFFFF_FF80, we=1; repeat unsigned -> 0x0000_0080.
- Half store 0xBEEF at 0x2002 -> dbus_we=1, sel=0011, dat_o=0xBEEF_BEEF; on ack wb_rf_r_we=0 and the pipeline advances.
- Word load at 0x3002 -> no dbus_cyc, no stall, next cycle wb_except_align=1, wb_except_addr=0x3002, wb_rf_r_we=0.
- Word load with dbus_err and ack asserted together -> wb_except_bus=1, wb_rf_r_we=0; with mem_flush pulsed during BUS instead -> no exception, no write, cyc held until ack.
- rst asserted mid-BUS, then back-to-back word loads 0x4000/0x4004 -> outputs zero after reset; each load takes 2+ cycles and writes in order.

Source files
------------

// File: rtl/eco32f_lsu_writeback.sv
// eco32f MEM-stage load/store unit and WB register. Runs one single-beat data-bus
// transfer per load/store, aligns big-endian load data and drives the register-file write port.
module eco32f_lsu_writeback #(
  parameter int DBUS_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  input  logic                       mem_flush,
  input  logic [4:0]                 mem_rf_r_addr,
  input  logic                       mem_rf_r_we,
  input  logic [31:0]                mem_alu_result,
  input  logic                       mem_op_load,
  input  logic                       mem_op_store,
  input  logic [1:0]                 mem_lsu_size,
  input  logic                       mem_lsu_signed,
  input  logic [31:0]                mem_store_data,
  output logic                       mem_stall,
  output logic                       dbus_cyc,
  output logic                       dbus_we,
  output logic [DBUS_ADDR_WIDTH-1:0] dbus_adr,
  output logic [3:0]                 dbus_sel,
  output logic [31:0]                dbus_dat_o,
  input  logic [31:0]                dbus_dat_i,
  input  logic                       dbus_ack,
  input  logic                       dbus_err,
  output logic [4:0]                 wb_rf_r_addr,
  output logic                       wb_rf_r_we,
  output logic [31:0]                wb_rf_r,
  output logic                       wb_except_align,
  output logic                       wb_except_bus,
  output logic [31:0]                wb_except_addr
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state, state_nxt;
  logic        killed;
  logic [1:0]  size_q, off_q;
  logic        signed_q;
  logic        is_mem, access, misalign, start, err, exc_align, exc_bus;
  logic [3:0]  sel_nxt;
  logic [31:0] dat_nxt, load_data;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Misalignment only has meaning for memory ops; ALU results are never checked.
  always_comb begin
    is_mem = mem_op_load | mem_op_store;
    case (mem_lsu_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = is_mem & mem_alu_result[0];
      default: misalign = is_mem & (mem_alu_result[1:0] != 2'b00);
    endcase
    access    = mem_valid & is_mem & ~mem_flush;
    start     = access & ~misalign & (state == IDLE);
    err       = (state == BUS) & dbus_err;
    mem_stall = start | ((state == BUS) & ~(dbus_ack | dbus_err));
    exc_align = access & misalign;
    exc_bus   = err & ~killed & ~mem_flush;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUS;
      BUS:     if (dbus_ack | dbus_err) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign dbus_cyc = (state == BUS);

  // Byte lanes: sel[3] is big-endian byte 0; store data is replicated across lanes.
  always_comb begin
    case (mem_lsu_size)
      2'd0: begin
        sel_nxt = 4'b1000 >> mem_alu_result[1:0];
        dat_nxt = {4{mem_store_data[7:0]}};
      end
      2'd1: begin
        sel_nxt = mem_alu_result[1] ? 4'b0011 : 4'b1100;
        dat_nxt = {2{mem_store_data[15:0]}};
      end
      default: begin
        sel_nxt = 4'b1111;
        dat_nxt = mem_store_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbus_we    <= 1'b0;
      dbus_adr   <= '0;
      dbus_sel   <= 4'b0000;
      dbus_dat_o <= 32'h0;
      size_q     <= 2'd0;
      off_q      <= 2'd0;
      signed_q   <= 1'b0;
      killed     <= 1'b0;
    end else if (start) begin
      dbus_we    <= mem_op_store;
      dbus_adr   <= {mem_alu_result[DBUS_ADDR_WIDTH-1:2], 2'b00};
      dbus_sel   <= sel_nxt;
      dbus_dat_o <= dat_nxt;
      size_q     <= mem_lsu_size;
      off_q      <= mem_alu_result[1:0];
      signed_q   <= mem_lsu_signed;
      killed     <= 1'b0;
    end else if ((state == BUS) && mem_flush) begin
      // A flushed transfer still runs to completion; only its result is dropped.
      killed     <= 1'b1;
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    byte_lane = dbus_dat_i[31:24];
      2'd1:    byte_lane = dbus_dat_i[23:16];
      2'd2:    byte_lane = dbus_dat_i[15:8];
      default: byte_lane = dbus_dat_i[7:0];
    endcase
    half_lane = off_q[1] ? dbus_dat_i[15:0] : dbus_dat_i[31:16];
    case (size_q)
      2'd0:    load_data = {{24{signed_q & byte_lane[7]}}, byte_lane};
      2'd1:    load_data = {{16{signed_q & half_lane[15]}}, half_lane};
      default: load_data = dbus_dat_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_rf_r_addr    <= 5'd0;
      wb_rf_r_we      <= 1'b0;
      wb_rf_r         <= 32'h0;
      wb_except_align <= 1'b0;
      wb_except_bus   <= 1'b0;
      wb_except_addr  <= 32'h0;
    end else if (mem_stall) begin
      wb_rf_r_we      <= 1'b0;
      wb_except_align <= 1'b0;
      wb_except_bus   <= 1'b0;
      wb_except_addr  <= 32'h0;
    end else begin
      wb_rf_r_addr    <= mem_rf_r_addr;
      wb_rf_r         <= mem_op_load ? load_data : mem_alu_result;
      wb_rf_r_we      <= mem_valid & mem_rf_r_we & ~mem_flush & ~killed & ~misalign
                         & ~err & ~mem_op_store;
      wb_except_align <= exc_align;
      wb_except_bus   <= exc_bus;
      wb_except_addr  <= (exc_align | exc_bus) ? mem_alu_result : 32'h0;
    end
  end

endmodule

// File: tb/tb_eco32f_lsu_writeback.sv
// Bench for eco32f_lsu_writeback: single-cycle vector table, directed bus sequences
// and randomized loads/stores against a byte-level reference model.
module tb_eco32f_lsu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_flush, mem_rf_r_we, mem_op_load, mem_op_store, mem_lsu_signed;
  logic [4:0]  mem_rf_r_addr;
  logic [31:0] mem_alu_result, mem_store_data;
  logic [1:0]  mem_lsu_size;
  logic        mem_stall, dbus_cyc, dbus_we, dbus_ack, dbus_err;
  logic [31:0] dbus_adr, dbus_dat_o, dbus_dat_i;
  logic [3:0]  dbus_sel;
  logic [4:0]  wb_rf_r_addr;
  logic        wb_rf_r_we, wb_except_align, wb_except_bus;
  logic [31:0] wb_rf_r, wb_except_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  eco32f_lsu_writeback #(.DBUS_ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_flush(mem_flush),
    .mem_rf_r_addr(mem_rf_r_addr), .mem_rf_r_we(mem_rf_r_we),
    .mem_alu_result(mem_alu_result), .mem_op_load(mem_op_load), .mem_op_store(mem_op_store),
    .mem_lsu_size(mem_lsu_size), .mem_lsu_signed(mem_lsu_signed), .mem_store_data(mem_store_data),
    .mem_stall(mem_stall),
    .dbus_cyc(dbus_cyc), .dbus_we(dbus_we), .dbus_adr(dbus_adr), .dbus_sel(dbus_sel),
    .dbus_dat_o(dbus_dat_o), .dbus_dat_i(dbus_dat_i), .dbus_ack(dbus_ack), .dbus_err(dbus_err),
    .wb_rf_r_addr(wb_rf_r_addr), .wb_rf_r_we(wb_rf_r_we), .wb_rf_r(wb_rf_r),
    .wb_except_align(wb_except_align), .wb_except_bus(wb_except_bus),
    .wb_except_addr(wb_except_addr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Gather the accessed big-endian bytes of the bus word, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] off);
    int n;
    logic [31:0] v;
    n = nbytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | ((w >> (8 * (3 - (int'(off) + i)))) & 32'hFF);
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  function automatic logic [3:0] ref_sel(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    for (int i = 0; i < nbytes(sz); i++) s[3 - (int'(off) + i)] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_dout(input logic [1:0] sz, input logic [31:0] d);
    int n;
    logic [31:0] v;
    n = nbytes(sz);
    v = 32'h0;
    for (int j = 0; j < 4; j++) v = (v << 8) | ((d >> (8 * (n - 1 - (j % n)))) & 32'hFF);
    return v;
  endfunction

  task automatic idle_inputs();
    mem_valid = 0; mem_flush = 0; mem_rf_r_we = 0; mem_op_load = 0; mem_op_store = 0;
    mem_lsu_signed = 0; mem_rf_r_addr = 0; mem_alu_result = 0; mem_store_data = 0;
    mem_lsu_size = 0; dbus_ack = 0; dbus_err = 0; dbus_dat_i = 0;
  endtask

  // Starts and ends one slot after a rising edge. Ack arrives in bus cycle 'lat'.
  task automatic run_mem(input logic ld, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] sdat, input logic [4:0] rd,
                         input logic [31:0] rdat, input int lat, input logic err_en,
                         input int flush_k);
    int stalls;
    logic killed, exp_we, exp_bus;
    stalls = 0;
    killed = 0;
    mem_valid = 1; mem_flush = 0; mem_rf_r_addr = rd; mem_rf_r_we = ld;
    mem_alu_result = addr; mem_op_load = ld; mem_op_store = !ld;
    mem_lsu_size = sz; mem_lsu_signed = sg; mem_store_data = sdat;
    #3;
    chk("start_stall", mem_stall, 1);
    if (mem_stall) stalls++;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      mem_flush = (k == flush_k);
      if (k == flush_k) killed = 1;
      chk("bus_cyc", dbus_cyc, 1);
      chk("bus_we", dbus_we, !ld);
      chk("bus_adr", dbus_adr, {addr[31:2], 2'b00});
      chk("bus_sel", dbus_sel, ref_sel(sz, addr[1:0]));
      chk("bus_dat_o", dbus_dat_o, ref_dout(sz, sdat));
      if (k == lat) begin
        dbus_ack = 1; dbus_err = err_en; dbus_dat_i = rdat;
      end else begin
        dbus_dat_i = $urandom;
      end
      #3;
      chk("bubble_we", wb_rf_r_we, 0);
      if (mem_stall) stalls++;
    end
    @(posedge clk); #1;
    dbus_ack = 0; dbus_err = 0; mem_flush = 0; mem_valid = 0;
    exp_we  = ld && !err_en && !killed;
    exp_bus = err_en && !killed;
    chk("stall_cycles", stalls, lat);
    chk("wb_addr", wb_rf_r_addr, rd);
    chk("wb_we", wb_rf_r_we, exp_we);
    if (exp_we) chk("wb_load_data", wb_rf_r, ref_load(rdat, sz, sg, addr[1:0]));
    if (!ld)    chk("wb_store_r", wb_rf_r, addr);
    chk("wb_exc_bus", wb_except_bus, exp_bus);
    chk("wb_exc_align", wb_except_align, 0);
    chk("wb_exc_addr", wb_except_addr, exp_bus ? addr : 32'h0);
    chk("cyc_released", dbus_cyc, 0);
  endtask

  typedef struct {
    logic v, fl, ld, st, rwe;
    logic [1:0] sz;
    logic [4:0] rd;
    logic [31:0] alu;
    logic e_we, e_al;
  } vec_t;

  vec_t vecs[10];

  task automatic apply_vec(input vec_t t);
    mem_valid = t.v; mem_flush = t.fl; mem_op_load = t.ld; mem_op_store = t.st;
    mem_rf_r_we = t.rwe; mem_lsu_size = t.sz; mem_rf_r_addr = t.rd; mem_alu_result = t.alu;
    mem_store_data = $urandom; mem_lsu_signed = 0;
    #3;
    chk("vec_stall", mem_stall, 0);
    @(posedge clk); #1;
    chk("vec_cyc", dbus_cyc, 0);
    chk("vec_wb_we", wb_rf_r_we, t.e_we);
    chk("vec_wb_addr", wb_rf_r_addr, t.rd);
    if (t.e_we) chk("vec_wb_r", wb_rf_r, t.alu);
    chk("vec_exc_align", wb_except_align, t.e_al);
    chk("vec_exc_addr", wb_except_addr, t.e_al ? t.alu : 32'h0);
    chk("vec_exc_bus", wb_except_bus, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    //          v  fl ld st rwe sz    rd     alu            we al
    vecs[0] = '{1, 0, 0, 0, 1, 2'd0, 5'd5,  32'h1234_5678, 1, 0};
    vecs[1] = '{1, 0, 0, 0, 1, 2'd0, 5'd0,  32'hDEAD_BEEF, 1, 0};
    vecs[2] = '{1, 1, 0, 0, 1, 2'd0, 5'd9,  32'h0000_0042, 0, 0};
    vecs[3] = '{0, 0, 0, 0, 1, 2'd0, 5'd3,  32'h0000_0077, 0, 0};
    vecs[4] = '{1, 0, 0, 0, 0, 2'd0, 5'd4,  32'h0000_0011, 0, 0};
    vecs[5] = '{1, 0, 1, 0, 1, 2'd2, 5'd7,  32'h0000_3002, 0, 1};
    vecs[6] = '{1, 0, 0, 1, 0, 2'd1, 5'd8,  32'h0000_2001, 0, 1};
    vecs[7] = '{1, 0, 1, 0, 1, 2'd3, 5'd10, 32'h0000_5003, 0, 1};
    vecs[8] = '{1, 1, 1, 0, 1, 2'd1, 5'd11, 32'h0000_6001, 0, 0};
    vecs[9] = '{0, 0, 0, 1, 0, 2'd2, 5'd12, 32'h0000_8001, 0, 0};

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc", dbus_cyc, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_sel", dbus_sel, 0);
    chk("rst_wb_we", wb_rf_r_we, 0);
    chk("rst_wb_r", wb_rf_r, 0);
    rst = 0;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Signed / unsigned byte load at 0x1001, ack in the 4th bus cycle.
    run_mem(1, 2'd0, 1, 32'h0000_1001, 32'h0, 5'd6, 32'h1180_2233, 4, 0, 0);
    run_mem(1, 2'd0, 0, 32'h0000_1001, 32'h0, 5'd6, 32'h1180_2233, 4, 0, 0);
    // Half store 0xBEEF at 0x2002.
    run_mem(0, 2'd1, 0, 32'h0000_2002, 32'h0000_BEEF, 5'd1, 32'h0, 2, 0, 0);
    // Word load with err and ack together, then one flushed during the transfer.
    run_mem(1, 2'd2, 0, 32'h0000_3000, 32'h0, 5'd2, 32'hCAFE_F00D, 2, 1, 0);
    run_mem(1, 2'd2, 0, 32'h0000_3004, 32'h0, 5'd2, 32'hCAFE_F00D, 3, 0, 1);

    // Reset in the middle of a transfer.
    mem_valid = 1; mem_op_load = 1; mem_rf_r_we = 1; mem_rf_r_addr = 5'd13;
    mem_lsu_size = 2'd2; mem_alu_result = 32'h0000_9000;
    @(posedge clk); #1;
    chk("pre_rst_cyc", dbus_cyc, 1);
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("midrst_cyc", dbus_cyc, 0);
    chk("midrst_adr", dbus_adr, 0);
    chk("midrst_dat_o", dbus_dat_o, 0);
    chk("midrst_stall", mem_stall, 0);
    chk("midrst_wb_addr", wb_rf_r_addr, 0);
    chk("midrst_wb_r", wb_rf_r, 0);

    // Back-to-back word loads.
    run_mem(1, 2'd2, 0, 32'h0000_4000, 32'h0, 5'd14, 32'hA5A5_0001, 1, 0, 0);
    run_mem(1, 2'd2, 1, 32'h0000_4004, 32'h0, 5'd15, 32'h8000_0002, 1, 0, 0);

    // Randomized aligned loads/stores interleaved with ALU ops.
    for (int it = 0; it < 40; it++) begin
      logic ld;
      logic [1:0] sz, off;
      int lat, fk;
      vec_t alu_v;
      ld  = $urandom_range(0, 1);
      sz  = 2'($urandom_range(0, 3));
      off = (sz == 2'd0) ? 2'($urandom_range(0, 3)) : (sz == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
      lat = $urandom_range(1, 4);
      fk  = (lat > 1 && $urandom_range(0, 7) == 0) ? $urandom_range(1, lat - 1) : 0;
      run_mem(ld, sz, 1'($urandom_range(0, 1)), {$urandom} & 32'hFFFF_FFFC | 32'(off), $urandom,
              5'($urandom), $urandom, lat, $urandom_range(0, 7) == 0, fk);
      if (it % 4 == 0) begin
        alu_v = '{1, 0, 0, 0, 1, 2'd0, 5'($urandom), $urandom, 1, 0};
        apply_vec(alu_v);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
